// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Loads a framed, checksummed byte stream into instruction memory
//            and holds the core in reset until a verified load completes.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_written
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] c_base  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [16:0]           c_depth = 17'(1) << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  r_rx_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_core_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [15:0]           r_words_written;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_words_left;
    logic [1:0]            r_idx;
    logic [23:0]           r_word;
    logic [7:0]            r_xor;

    logic                  w_accept;
    logic                  w_idle_like;
    logic                  w_arm;
    logic [15:0]           w_len;
    logic                  w_len_ovf;
    logic                  w_last_byte;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_arm       = start && w_idle_like;
    assign w_len       = {rx_data, r_len_lo};
    assign w_len_ovf   = {1'b0, w_len} > c_depth;
    assign w_last_byte = (r_idx == 2'd3) && (r_words_left == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_ovf)          w_next = S_ERR;
                    else if (w_len == 16'd0) w_next = S_CHK;
                    else                     w_next = S_DATA;
                end
            end
            S_DATA: begin
                // The final strobe overlaps CHK so the checksum byte never stalls.
                if (w_accept && w_last_byte) w_next = S_CHK;
            end
            S_CHK: begin
                if (w_accept) w_next = (rx_data == r_xor) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ready      <= 1'b0;
            r_imem_we       <= 1'b0;
            r_imem_addr     <= c_base;
            r_imem_wdata    <= 32'd0;
            r_core_hold     <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= 16'd0;
            r_len_lo        <= 8'd0;
            r_words_left    <= 16'd0;
            r_idx           <= 2'd0;
            r_word          <= 24'd0;
            r_xor           <= 8'd0;
        end else begin
            r_rx_ready <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                          (w_next == S_DATA)   || (w_next == S_CHK);
            r_imem_we  <= 1'b0;
            if (r_imem_we) begin
                r_imem_addr     <= r_imem_addr + 1'b1;
                r_words_written <= r_words_written + 16'd1;
            end
            if (w_arm) begin
                r_imem_addr     <= c_base;
                r_core_hold     <= 1'b1;
                r_busy          <= 1'b1;
                r_done          <= 1'b0;
                r_error         <= 1'b0;
                r_words_written <= 16'd0;
                r_xor           <= 8'd0;
                r_idx           <= 2'd0;
            end
            case (r_state)
                S_LEN_LO: begin
                    if (w_accept) r_len_lo <= rx_data;
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_words_left <= w_len;
                        r_idx        <= 2'd0;
                        if (w_len_ovf) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_xor <= r_xor ^ rx_data;
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_word[7:0]   <= rx_data;
                            2'd1: r_word[15:8]  <= rx_data;
                            2'd2: r_word[23:16] <= rx_data;
                            default: begin
                                r_imem_we    <= 1'b1;
                                r_imem_wdata <= {rx_data, r_word};
                                r_words_left <= r_words_left - 16'd1;
                            end
                        endcase
                    end
                end
                S_CHK: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready      = r_rx_ready;
    assign imem_we       = r_imem_we;
    assign imem_addr     = r_imem_addr;
    assign imem_wdata    = r_imem_wdata;
    assign core_hold     = r_core_hold;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words_written;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed self-checking bench for imem_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int checks = 0;
    int failures = 0;

    logic [7:0]  seq[$];
    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    imem_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_hold(core_hold), .busy(busy), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Each cycle with the strobe high is logged, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    // Entered and left on a falling edge; leaves rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout rx_ready=%b required=1", rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input bit gaps, input int start_at);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(seq[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_nominal(input logic [7:0] chk);
        seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, chk};
    endtask

    task automatic check_two_writes(input string tag);
        checks++;
        if (wa.size() !== 2) begin
            failures++;
            $display("FAIL %s_write_count got=%0d required=2", tag, wa.size());
        end else begin
            checks++;
            if ({wa[0], wd[0], wa[1], wd[1]} !== {8'd0, 32'h00500093, 8'd1, 32'h00100113}) begin
                failures++;
                $display("FAIL %s_writes got=(%0h,%h)(%0h,%h) required=(0,00500093)(1,00100113)",
                         tag, wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, imem_we, core_hold, busy, done, error} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=001000",
                     {rx_ready, imem_we, core_hold, busy, done, error});
        end
        checks++;
        if ({imem_addr, imem_wdata, words_written} !== 56'd0) begin
            failures++;
            $display("FAIL reset_values got addr=%0h wdata=%h ww=%0d required=0,0,0",
                     imem_addr, imem_wdata, words_written);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        wa.delete(); wd.delete();
        pulse_start();
        checks++;
        if ({busy, core_hold, rx_ready, done, error} !== 5'b11100) begin
            failures++;
            $display("FAIL nominal_armed got=%b required=11100", {busy, core_hold, rx_ready, done, error});
        end
        load_nominal(8'hC1);
        send_seq(1'b0, -1);
        repeat (2) @(negedge clk);
        check_two_writes("nominal");
        checks++;
        if ({done, error, core_hold, busy, rx_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL nominal_end got=%b required=10000", {done, error, core_hold, busy, rx_ready});
        end
        checks++;
        if (words_written !== 16'd2) begin
            failures++;
            $display("FAIL nominal_words_written got=%0d required=2", words_written);
        end
    endtask

    task automatic test_bad_checksum();
        wa.delete(); wd.delete();
        pulse_start();
        checks++;
        if ({core_hold, done, busy} !== 3'b101) begin
            failures++;
            $display("FAIL rearm_from_done got=%b required=101", {core_hold, done, busy});
        end
        load_nominal(8'hC0);
        send_seq(1'b0, -1);
        repeat (2) @(negedge clk);
        check_two_writes("badchk");
        checks++;
        if ({error, done, core_hold, busy} !== 4'b1010) begin
            failures++;
            $display("FAIL badchk_end got=%b required=1010", {error, done, core_hold, busy});
        end
    endtask

    task automatic test_overflow();
        wa.delete(); wd.delete();
        pulse_start();
        seq = '{8'h01, 8'h01};
        send_seq(1'b0, -1);
        checks++;
        if ({error, rx_ready, busy, done, core_hold} !== 5'b10001) begin
            failures++;
            $display("FAIL overflow_err got=%b required=10001", {error, rx_ready, busy, done, core_hold});
        end
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({rx_ready, error, wa.size() == 0} !== 3'b011) begin
            failures++;
            $display("FAIL overflow_after got ready=%b err=%b writes=%0d required 0,1,0",
                     rx_ready, error, wa.size());
        end
    endtask

    task automatic test_zero_length();
        wa.delete(); wd.delete();
        pulse_start();
        seq = '{8'h00, 8'h00, 8'h00};
        send_seq(1'b0, -1);
        checks++;
        if ({done, error, core_hold, words_written == 16'd0, wa.size() == 0} !== 5'b10011) begin
            failures++;
            $display("FAIL zero_ok got done=%b err=%b hold=%b ww=%0d writes=%0d required 1,0,0,0,0",
                     done, error, core_hold, words_written, wa.size());
        end
        pulse_start();
        seq = '{8'h00, 8'h00, 8'h01};
        send_seq(1'b0, -1);
        checks++;
        if ({done, error, core_hold} !== 3'b011) begin
            failures++;
            $display("FAIL zero_badchk got=%b required=011", {done, error, core_hold});
        end
    endtask

    // Start together with a byte in an idle-like state: only start may act.
    task automatic test_start_collision();
        wa.delete(); wd.delete();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        seq = '{8'h00, 8'h00, 8'h00};
        send_seq(1'b0, -1);
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            failures++;
            $display("FAIL start_collision got=%b required=100", {done, error, busy});
        end
    endtask

    task automatic test_flow_control();
        wa.delete(); wd.delete();
        pulse_start();
        load_nominal(8'hC1);
        send_seq(1'b1, 5);
        repeat (2) @(negedge clk);
        check_two_writes("flow");
        checks++;
        if ({done, error, core_hold, words_written} !== {3'b100, 16'd2}) begin
            failures++;
            $display("FAIL flow_end got done=%b err=%b hold=%b ww=%0d required 1,0,0,2",
                     done, error, core_hold, words_written);
        end
    endtask

    task automatic test_reset_mid_word();
        wa.delete(); wd.delete();
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h93, 8'h00};
        send_seq(1'b0, -1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_ready, imem_we, core_hold, busy, done, error} !== 6'b001000) begin
            failures++;
            $display("FAIL midreset_flags got=%b required=001000",
                     {rx_ready, imem_we, core_hold, busy, done, error});
        end
        checks++;
        if ({imem_addr, imem_wdata, words_written} !== 56'd0) begin
            failures++;
            $display("FAIL midreset_values got addr=%0h wdata=%h ww=%0d required=0,0,0",
                     imem_addr, imem_wdata, words_written);
        end
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        load_nominal(8'hC1);
        send_seq(1'b0, -1);
        repeat (2) @(negedge clk);
        check_two_writes("after_reset");
        checks++;
        if ({done, error, core_hold} !== 3'b100) begin
            failures++;
            $display("FAIL after_reset_end got=%b required=100", {done, error, core_hold});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_overflow();
        test_zero_length();
        test_start_collision();
        test_flow_control();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware program loader for the single-cycle RISC-V core; the synthesizable counterpart of loading instruction memory from a hex file.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes those words into the instruction memory write port, holding the core in reset until a checksum-verified load completes.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written (word units).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that arms a new load.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address; byte address = imem_addr<<2 at integration.
- imem_wdata  out  32  assembled instruction word.
- core_hold  out  1  high = processor held in reset.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed and checksum matched.
- error  out  1  sticky: last load failed (length overflow or checksum mismatch).
- words_written  out  16  count of words written in the current/last load.

Behaviour:
- Reset values: state IDLE; rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, busy=0, done=0, error=0, words_written=0, byte index=0, xor accumulator=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes with each word LSB first, then one CHK byte equal to the XOR of all data bytes. Length bytes are excluded from the XOR.
- Byte acceptance: a byte is accepted on a rising edge with rx_valid && rx_ready.
  - rx_ready=1 only in LEN_LO, LEN_HI, DATA and CHK; 0 in IDLE, DONE and ERR.
  - rx_ready is a registered function of state, never of rx_valid.
- IDLE:
  - start -> LEN_LO; clear done, error, words_written and xor; imem_addr=BASE_ADDR; busy=1; core_hold=1.
- LEN_LO: accept byte -> latch N[7:0] -> LEN_HI.
- LEN_HI: accept byte -> latch N[15:8], then:
  - N > 2^ADDR_WIDTH -> ERR; no writes occur.
  - N == 0 -> CHK.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte shifts into the word at lane byte-index (0..3) and is XORed into the accumulator.
  - On accepting byte index 3: next cycle imem_we=1 for exactly one cycle with the full word on imem_wdata and the current address on imem_addr. In the cycle after the strobe, imem_addr increments and words_written increments.
  - Back-to-back bytes are accepted every cycle. The write strobe must not stall rx_ready.
  - After word N is strobed -> CHK.
  - imem_addr wraps modulo 2^ADDR_WIDTH. This is only reachable when BASE_ADDR≠0; it is legal and must not flag an error.
- CHK: accept byte:
  - Equal to accumulator -> DONE: done=1, busy=0, core_hold=0.
  - Otherwise -> ERR: error=1, busy=0, core_hold stays 1.
- DONE/ERR: start -> re-arm exactly as from IDLE, with core_hold re-asserted that same cycle.
- start while busy (LEN_LO..CHK) is ignored.
- rx_valid with rx_ready=0: byte is not consumed and has no effect.
- rst at any cycle, including mid-word or mid-strobe, returns all outputs to reset values on the next edge. Partial words are discarded; memory already written is not rolled back.
- Simultaneous start and rx_valid in IDLE: only start acts; the byte is not accepted (rx_ready=0 that cycle).

Test Plan:
- Nominal load: BASE_ADDR=0; start, then bytes 02 00 | 93 00 50 00 | 13 01 10 00 | C1. Required: imem_we pulses twice — (addr 0, 0x00500093) and (addr 1, 0x00100113); then done=1, core_hold=0, error=0, words_written=2, busy=0.
- Bad checksum: same stream with last byte C0. Required: two writes occur, then error=1, done=0, core_hold=1.
- Overflow: ADDR_WIDTH=8, length bytes 01 01 (N=257). Required: ERR immediately after LEN_HI, no imem_we, rx_ready=0 thereafter.
- Zero length: start, then bytes 00 00 00. Required: no writes, done=1, core_hold=0. Repeating with checksum byte 01 instead of 00 must give error=1.
- Flow control: insert random rx_valid gaps inside words, and issue start mid-load. Required: written words are identical to the nominal case and the mid-load start is ignored.
- Reset mid-word after 2 data bytes: assert rst. Required: all outputs at reset values the next cycle. A fresh nominal load then succeeds with the correct words.
